// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA requester, the data memory and dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic              cpu_src;
    logic [31:0]       cpu_alu_addr;
    logic [ADDR_W-1:0] cpu_non_alu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall_mem;

    logic              dma_req;
    logic              dma_we;
    logic              dma_lock;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_src, cpu_alu_addr, cpu_non_alu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, stall_mem,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_src, cpu_alu_addr, cpu_non_alu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, stall_mem,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage vs. DMA, CPU-priority with
// starvation override and bounded DMA lock bursts; stalls the pipeline on CPU loss.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int LOCK_W   = $clog2(MAX_LOCK + 1);

    typedef enum logic {CPU_OWN, DMA_OWN} state_t;

    state_t              state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [LOCK_W-1:0]   lock_inc;
    logic                cpu_req;
    logic                starve_hit;
    logic                dma_hold;
    logic                dma_win;
    logic                cpu_win;
    logic [ADDR_W-1:0]   cpu_addr;
    logic                unused_addr_bits;

    assign cpu_req    = bus.cpu_rd | bus.cpu_wr;
    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign dma_hold   = (state == DMA_OWN) & bus.dma_req & bus.dma_lock;
    assign dma_win    = dma_hold | (bus.dma_req & (~cpu_req | starve_hit));
    assign cpu_win    = ~dma_win & cpu_req;
    assign cpu_addr   = bus.cpu_src ? bus.cpu_non_alu_addr : bus.cpu_alu_addr[ADDR_W-1:0];
    assign lock_inc   = lock_cnt + 1'b1;
    assign unused_addr_bits = ^bus.cpu_alu_addr[31:ADDR_W];

    // Grants are gated by rst so every memory-side output is 0 while in reset.
    always_comb begin
        bus.cpu_gnt   = rst & cpu_win;
        bus.dma_gnt   = rst & dma_win;
        bus.stall_mem = rst & cpu_req & ~cpu_win;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.dma_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (bus.cpu_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_wr;
            bus.mem_addr  = cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= CPU_OWN;
            starve_cnt     <= '0;
            lock_cnt       <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.dma_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= bus.cpu_gnt & ~bus.cpu_wr;
            bus.dma_rvalid <= bus.dma_gnt & ~bus.dma_we;

            if (bus.dma_req & ~bus.dma_gnt) begin
                if (!starve_hit)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (bus.dma_gnt && bus.dma_lock && (lock_inc < LOCK_W'(MAX_LOCK))) begin
                state    <= DMA_OWN;
                lock_cnt <= lock_inc;
            end else begin
                state    <= CPU_OWN;
                lock_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: reset, CPU access, starvation,
// lock bursts, lock drop, address select and reset in the middle of a burst.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(12),
        .DATA_W(32),
        .STARVE_LIMIT(4),
        .MAX_LOCK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_rd           = 1'b0;
        bus.cpu_wr           = 1'b0;
        bus.cpu_src          = 1'b0;
        bus.cpu_alu_addr     = '0;
        bus.cpu_non_alu_addr = '0;
        bus.cpu_wdata        = '0;
        bus.dma_req          = 1'b0;
        bus.dma_we           = 1'b0;
        bus.dma_lock         = 1'b0;
        bus.dma_addr         = '0;
        bus.dma_wdata        = '0;
        bus.mem_rdata        = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1;
        check("rst_cpu_gnt", bus.cpu_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_dma_rvalid", bus.dma_rvalid, 0);
        cycle();
        rst = 1'b1;
        cycle(); idle();

        // CPU only read via non-ALU address
        bus.cpu_rd = 1; bus.cpu_src = 1; bus.cpu_non_alu_addr = 12'h0A5; bus.cpu_alu_addr = 32'h123;
        #1;
        check("cpu_mem_en", bus.mem_en, 1);
        check("cpu_mem_we", bus.mem_we, 0);
        check("cpu_mem_addr", bus.mem_addr, 12'h0A5);
        check("cpu_gnt", bus.cpu_gnt, 1);
        check("cpu_stall", bus.stall_mem, 0);
        check("cpu_no_dma", bus.dma_gnt, 0);
        cycle(); idle(); bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        check("cpu_rvalid", bus.cpu_rvalid, 1);
        check("cpu_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
        check("idle_mem_en", bus.mem_en, 0);
        cycle();
        #1;
        check("cpu_rvalid_pulse", bus.cpu_rvalid, 0);

        // Starvation: CPU wins 4 cycles, DMA forced on cycle 5
        for (int i = 1; i <= 5; i++) begin
            cycle();
            bus.cpu_wr = 1; bus.cpu_alu_addr = 32'h10; bus.cpu_wdata = 32'h55;
            bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 12'h200; bus.dma_wdata = 32'h77;
            #1;
            if (i < 5) begin
                check("starve_cpu_gnt", bus.cpu_gnt, 1);
                check("starve_no_stall", bus.stall_mem, 0);
                check("starve_addr_cpu", bus.mem_addr, 12'h010);
            end else begin
                check("starve_dma_gnt", bus.dma_gnt, 1);
                check("starve_cpu_lost", bus.cpu_gnt, 0);
                check("starve_stall", bus.stall_mem, 1);
                check("starve_addr_dma", bus.mem_addr, 12'h200);
                check("starve_wdata_dma", bus.mem_wdata, 32'h77);
            end
        end
        cycle(); bus.dma_req = 0;
        #1;
        check("starve_after_cpu", bus.cpu_gnt, 1);
        check("starve_after_stall", bus.stall_mem, 0);
        cycle(); bus.dma_req = 1;
        #1;
        check("starve_cleared", bus.cpu_gnt, 1);
        cycle(); idle();

        // Lock burst: 8 DMA beats, CPU read waits from beat 2, wins cycle 9
        for (int c = 1; c <= 12; c++) begin
            cycle();
            bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 0; bus.dma_addr = 12'(c);
            bus.cpu_rd = (c >= 2 && c <= 9); bus.cpu_src = 1; bus.cpu_non_alu_addr = 12'h333;
            bus.mem_rdata = 32'h1000 + 32'(c);
            #1;
            if (c <= 8) begin
                check("lock_dma_gnt", bus.dma_gnt, 1);
                check("lock_stall", bus.stall_mem, (c >= 2));
            end else if (c == 9) begin
                check("lock_cpu_gnt", bus.cpu_gnt, 1);
                check("lock_dma_denied", bus.dma_gnt, 0);
                check("lock_addr_cpu", bus.mem_addr, 12'h333);
            end else begin
                check("lock_dma_again", bus.dma_gnt, 1);
            end
            if (c == 2) begin
                check("lock_dma_rvalid", bus.dma_rvalid, 1);
                check("lock_dma_rdata", bus.dma_rdata, 32'h1002);
            end
        end

        // Reset mid-burst: DMA_OWN with lock_cnt = 3, beat 4 being issued
        cycle();
        bus.cpu_rd = 1;
        #1;
        check("midburst_hold", bus.dma_gnt, 1);
        rst = 1'b0;
        #1;
        check("rstmid_dma_gnt", bus.dma_gnt, 0);
        check("rstmid_cpu_gnt", bus.cpu_gnt, 0);
        check("rstmid_stall", bus.stall_mem, 0);
        check("rstmid_mem_en", bus.mem_en, 0);
        check("rstmid_mem_we", bus.mem_we, 0);
        check("rstmid_dma_rvalid", bus.dma_rvalid, 0);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            rst = 1'b1;
            #1;
            if (i == 1) check("rstrel_dma_rvalid", bus.dma_rvalid, 0);
            if (i < 5) check("rstrel_cpu_own", bus.cpu_gnt, 1);
            else       check("rstrel_starve_fresh", bus.dma_gnt, 1);
        end
        cycle(); idle();

        // Lock drop after beat 3 with CPU write pending
        for (int c = 1; c <= 4; c++) begin
            cycle();
            bus.dma_req = 1; bus.dma_lock = (c <= 3); bus.dma_we = 1;
            bus.cpu_wr = (c >= 2); bus.cpu_alu_addr = 32'h44;
            #1;
            if (c <= 3) begin
                check("drop_dma_gnt", bus.dma_gnt, 1);
            end else begin
                check("drop_cpu_gnt", bus.cpu_gnt, 1);
                check("drop_dma_denied", bus.dma_gnt, 0);
                check("drop_no_stall", bus.stall_mem, 0);
            end
        end
        cycle(); idle();

        // Address select from ALU, write
        bus.cpu_wr = 1; bus.cpu_src = 0; bus.cpu_alu_addr = 32'h0001_2FFC;
        bus.cpu_non_alu_addr = 12'h111; bus.cpu_wdata = 32'hDEAD_BEEF;
        #1;
        check("asel_addr", bus.mem_addr, 12'hFFC);
        check("asel_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("asel_we", bus.mem_we, 1);
        check("asel_gnt", bus.cpu_gnt, 1);
        cycle(); bus.cpu_rd = 1;
        #1;
        check("wr_no_rvalid", bus.cpu_rvalid, 0);
        check("rdwr_is_write", bus.mem_we, 1);
        cycle(); idle();
        #1;
        check("rdwr_no_rvalid", bus.cpu_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU MEM stage (fed by the EX/MEM pipeline register) and a DMA requester.
- CPU has default priority. A starvation counter guarantees DMA progress, and a lock mechanism lets DMA run short back-to-back bursts.
- Asserts stall_mem to freeze the IF through EX/MEM pipeline whenever a CPU access loses arbitration.

Parameters:
ADDR_W, 12, data-memory word-address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied DMA-request cycles before DMA is forced to win
MAX_LOCK, 8, maximum consecutive DMA beats per ownership period

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cpu_rd  input  1  MEM-stage read (MemRead)
cpu_wr  input  1  MEM-stage write (MemWrite)
cpu_src  input  1  address select (MemSrc): 1 = cpu_non_alu_addr, 0 = cpu_alu_addr[ADDR_W-1:0]
cpu_alu_addr  input  32  ALU-computed address
cpu_non_alu_addr  input  12  non-ALU address (stack/call/ret)
cpu_wdata  input  DATA_W  store data
cpu_gnt  output  1  CPU access issued this cycle
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DATA_W  CPU read data
stall_mem  output  1  pipeline freeze request
dma_req  input  1  DMA request, held until granted
dma_we  input  1  DMA write (1) / read (0)
dma_lock  input  1  DMA requests continued ownership
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_gnt  output  1  DMA beat issued this cycle
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  DATA_W  DMA read data
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid one cycle after a read issue

Behaviour:
- Definitions: cpu_req = cpu_rd | cpu_wr. If both cpu_rd and cpu_wr are high, treat as a write. starve_hit = (starve_cnt == STARVE_LIMIT).
- State machine, two states: CPU_OWN (reset state) and DMA_OWN.
- Winner, combinational:
  - dma_hold = (state == DMA_OWN) & dma_req & dma_lock.
  - DMA wins if dma_hold | (dma_req & (~cpu_req | starve_hit)).
  - Otherwise CPU wins if cpu_req.
  - Otherwise no access: mem_en = 0.
- Grant outputs: cpu_gnt and dma_gnt are combinational and mutually exclusive. stall_mem = cpu_req & ~cpu_gnt.
- mem_en, mem_we, mem_addr and mem_wdata are driven combinationally from the winner. All four are 0 when there is no winner.
- Read data path:
  - cpu_rvalid is registered: it pulses one cycle after a CPU read grant. cpu_rdata = mem_rdata.
  - dma_rvalid is registered the same way. dma_rdata = mem_rdata.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments each cycle that dma_req is high and dma_gnt is low.
  - Clears on dma_gnt or when dma_req is low.
- lock_cnt, updated on each DMA grant:
  - lock_cnt_next = lock_cnt + 1.
  - Next state is DMA_OWN if dma_lock & (lock_cnt + 1 < MAX_LOCK).
  - Otherwise next state is CPU_OWN and lock_cnt clears.
- Cycles with a CPU grant or no grant: next state is CPU_OWN, lock_cnt = 0.
- Leaving DMA_OWN: if dma_req or dma_lock drops, the same cycle is arbitrated with CPU_OWN rules. There is no dead cycle.
- MAX_LOCK exhaustion: the following cycle uses CPU_OWN rules, so a pending CPU request wins unless starve_hit.
- Simultaneous CPU read and DMA write to the same address: no forwarding. Order is set purely by arbitration.
- Stall hold: while stall_mem is high, the pipeline holds the cpu_* inputs stable. The arbiter does not latch CPU requests.
- Reset (rst low, asynchronous, at any time including mid-burst):
  - State goes to CPU_OWN; starve_cnt, lock_cnt, cpu_rvalid and dma_rvalid go to 0.
  - Combinational outputs (cpu_gnt, dma_gnt, stall_mem, mem_en, mem_we) are forced to 0 while rst is low.
  - In-flight read responses are discarded.
- Latency: grant in the same cycle as the request when uncontended; read data one cycle after the grant.

Test Plan:
- Reset mid-burst: DMA_OWN with lock_cnt = 3, pulse rst low -> all outputs 0 immediately. After release: state CPU_OWN, dma_rvalid stays 0, counters zero.
- CPU only: cpu_rd = 1, cpu_src = 1, cpu_non_alu_addr = 0x0A5 -> same cycle mem_en = 1, mem_we = 0, mem_addr = 0x0A5, cpu_gnt = 1, stall_mem = 0. Next cycle cpu_rvalid = 1, cpu_rdata = mem_rdata.
- Starvation: cpu_wr held high, dma_req held high -> CPU granted 4 cycles, DMA granted on cycle 5 with stall_mem = 1 that cycle only. starve_cnt returns to 0.
- Lock burst: cpu_req idle, dma_req = dma_lock = 1 for 12 cycles, then cpu_rd asserted at beat 2 -> DMA keeps 8 beats (stall_mem = 1 during beats 2-8). CPU granted in cycle 9.
- Lock drop: dma_lock falls after beat 3 with cpu_wr pending -> next cycle cpu_gnt = 1, no idle cycle.
- Address select: cpu_src = 0, cpu_alu_addr = 0x0001_2FFC, write 0xDEADBEEF -> mem_addr = 0xFFC (ADDR_W = 12), mem_wdata = 0xDEADBEEF, mem_we = 1.
